// File: rtl/pipeline_datapath_elastic_if.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_datapath_elastic_if
// Description : Valid/ready handshake bundle for the elastic arithmetic
//               pipeline. It carries the upstream (in_*) and downstream
//               (out_*) channels.
//               slave  : pipeline view (consumes in_*, produces out_*)
//               master : environment view (produces in_*, consumes out_*)
// Ports       : in_valid/in_ready/in_data   - upstream beat channel
//               out_valid/out_ready/out_data - downstream beat channel
// Revision    : 1.0 - initial release
// ============================================================================
interface pipeline_datapath_elastic_if #(
  parameter int DATA_W = 16
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;

  modport slave (
    input  in_valid,
    input  in_data,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data
  );

  modport master (
    output in_valid,
    output in_data,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data
  );
endinterface
`default_nettype wire

// File: rtl/pipeline_datapath_elastic.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_datapath_elastic
// Description : Three-stage elastic arithmetic pipeline.
//                 stage 1 : d1 = in_data + ADD_K
//                 stage 2 : d2 = d1 * MUL_K
//                 stage 3 : d3 = (d2 & AND_MASK) ^ XOR_KEY
//               All arithmetic wraps modulo 2^DATA_W. Each stage stalls only
//               when it is full and the stage after it cannot take its beat,
//               so bubbles collapse. flush empties the pipe synchronously.
//               beat_cnt counts output transfers and wraps.
// Ports       : clk       - rising-edge clock
//               rst_n     - asynchronous active-low reset
//               flush     - synchronous flush of all in-flight beats
//               bus       - handshake bundle (slave modport)
//               beat_cnt  - number of out_valid & out_ready transfers
// Revision    : 1.0 - initial release
// ============================================================================
module pipeline_datapath_elastic #(
  parameter int DATA_W   = 16,
  parameter int ADD_K    = 5,
  parameter int MUL_K    = 3,
  parameter     AND_MASK = 16'h0FFF,
  parameter     XOR_KEY  = 16'h00AA,
  parameter int CNT_W    = 16
) (
  input  wire logic                    clk,
  input  wire logic                    rst_n,
  input  wire logic                    flush,
  pipeline_datapath_elastic_if.slave   bus,
  output logic [CNT_W-1:0]             beat_cnt
);

  // Constants fitted to the datapath width (truncate or zero-extend).
  localparam logic [DATA_W-1:0] c_add_k    = DATA_W'(ADD_K);
  localparam logic [DATA_W-1:0] c_mul_k    = DATA_W'(MUL_K);
  localparam logic [DATA_W-1:0] c_and_mask = DATA_W'(AND_MASK);
  localparam logic [DATA_W-1:0] c_xor_key  = DATA_W'(XOR_KEY);

  logic              r_v1, r_v2, r_v3;
  logic [DATA_W-1:0] r_d1, r_d2, r_d3;
  logic [CNT_W-1:0]  r_cnt;

  logic              w_r1, w_r2, w_r3;
  logic              w_in_ready;
  logic              w_v0;
  logic              w_xfer;
  logic [DATA_W-1:0] w_s1, w_s2, w_s3;

  // Ready ripples backwards: a stage can load if it is empty or if its
  // current beat is leaving this cycle.
  assign w_r3       = !r_v3 | bus.out_ready;
  assign w_r2       = !r_v2 | w_r3;
  assign w_r1       = !r_v1 | w_r2;
  assign w_in_ready = w_r1 & !flush;
  assign w_v0       = bus.in_valid & w_in_ready;
  assign w_xfer     = r_v3 & bus.out_ready;

  assign w_s1 = bus.in_data + c_add_k;
  assign w_s2 = r_d1 * c_mul_k;
  assign w_s3 = (r_d2 & c_and_mask) ^ c_xor_key;

  // Valid bits. flush wins over any load; the flush cycle still lets the
  // stage-3 beat leave (counted below), but nothing is kept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v1 <= 1'b0;
      r_v2 <= 1'b0;
      r_v3 <= 1'b0;
    end else if (flush) begin
      r_v1 <= 1'b0;
      r_v2 <= 1'b0;
      r_v3 <= 1'b0;
    end else begin
      if (w_r1) r_v1 <= w_v0;
      if (w_r2) r_v2 <= r_v1;
      if (w_r3) r_v3 <= r_v2;
    end
  end

  // Data registers follow the stage ready only; contents of an empty stage
  // are don't-care, so they need no flush or valid qualification.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_d1 <= '0;
      r_d2 <= '0;
      r_d3 <= '0;
    end else begin
      if (w_r1) r_d1 <= w_s1;
      if (w_r2) r_d2 <= w_s2;
      if (w_r3) r_d3 <= w_s3;
    end
  end

  // Output transfer counter, wraps naturally at 2^CNT_W.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (w_xfer) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_v3;
  assign bus.out_data  = r_d3;
  assign beat_cnt      = r_cnt;

endmodule
`default_nettype wire
